k12a_mem_arbiter: RTL



---
 rtl/k12a_mem_arbiter_pkg.sv | 23 ++
 rtl/k12a_mem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/k12a_mem_arbiter_pkg.sv
// Shared types and widths for the k12a memory arbiter.
//   mem_mode_t      : memory access mode carried on the CPU and memory buses
//   mem_arb_state_t : arbiter ownership / access sequencing states
package k12a_mem_arbiter_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic {
    MEM_MODE_READ  = 1'b0,
    MEM_MODE_WRITE = 1'b1
  } mem_mode_t;

  typedef enum logic [2:0] {
    ARB_CPU    = 3'd0,
    ARB_ACCESS = 3'd1,
    ARB_STROBE = 3'd2,
    ARB_ACK    = 3'd3,
    ARB_HOLD   = 3'd4
  } mem_arb_state_t;

endpackage

// File: rtl/k12a_mem_arbiter.sv
// Shares the k12a memory port between the CPU datapath and a debug/loader
// requester. Debug is granted only at instruction boundaries or while the CPU
// is halted; the CPU is stalled for the whole debug tenure. A burst limit plus
// a yield flag guarantees at least one CPU instruction between debug tenures.
// Ports:
//   cpu_clock, reset                  : clock, synchronous active-high reset
//   cpu_mem_*, cpu_addr, cpu_wdata    : CPU-side memory request
//   cpu_at_boundary, cpu_halted       : CPU status used to gate the grant
//   cpu_stall                         : freezes CPU state while debug owns memory
//   dbg_req/write/addr/wdata          : debug level request and payload
//   dbg_grant, dbg_ack, dbg_rdata     : debug ownership, completion, read data
//   mem_*                             : memory-side bus, mem_rdata returned
module k12a_mem_arbiter
  import k12a_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              cpu_clock,
  input  logic              reset,
  input  logic              cpu_mem_enable,
  input  mem_mode_t         cpu_mem_mode,
  input  logic              cpu_async_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_at_boundary,
  input  logic              cpu_halted,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_grant,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_enable,
  output mem_mode_t         mem_mode,
  output logic              mem_async_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  mem_arb_state_t     state;
  logic [COUNT_W-1:0] count;
  logic               yield_flag;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic               lat_write;

  logic grant_c;
  logic burst_done_c;

  // A halted CPU cannot make progress anyway, so yield never blocks the loader.
  assign grant_c      = dbg_req & (cpu_at_boundary | cpu_halted) & ~(yield_flag & ~cpu_halted);
  assign burst_done_c = (count >= COUNT_W'(MAX_BURST));

  // Ownership sequencing, burst counter, yield flag and read-data capture.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state      <= ARB_CPU;
      count      <= '0;
      yield_flag <= 1'b0;
      dbg_rdata  <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_write  <= 1'b0;
    end else begin
      // CPU leaving fetch proves it stepped; later set in ARB_HOLD overrides.
      if (!cpu_at_boundary) yield_flag <= 1'b0;
      case (state)
        ARB_CPU: begin
          if (grant_c) begin
            state <= ARB_ACCESS;
            count <= '0;
          end
        end
        ARB_ACCESS: begin
          // Latch the payload so a request dropped mid-access still completes.
          lat_addr  <= dbg_addr;
          lat_wdata <= dbg_wdata;
          lat_write <= dbg_write;
          if (dbg_write) begin
            state <= ARB_STROBE;
          end else begin
            dbg_rdata <= mem_rdata;
            state     <= ARB_ACK;
          end
        end
        ARB_STROBE: state <= ARB_ACK;
        ARB_ACK: begin
          if (count != '1) count <= count + COUNT_W'(1);
          state <= ARB_HOLD;
        end
        ARB_HOLD: begin
          // While halted the burst limit is waived so back-to-back accesses never pause.
          if (dbg_req && (!burst_done_c || cpu_halted)) begin
            state <= ARB_ACCESS;
          end else begin
            state <= ARB_CPU;
            if (dbg_req) yield_flag <= 1'b1;
          end
        end
        default: state <= ARB_CPU;
      endcase
    end
  end

  // Memory bus mux and ownership outputs decoded from the current state.
  always_comb begin
    mem_enable      = cpu_mem_enable;
    mem_mode        = cpu_mem_mode;
    mem_async_write = cpu_async_write;
    mem_addr        = cpu_addr;
    mem_wdata       = cpu_wdata;
    dbg_grant       = 1'b1;
    cpu_stall       = 1'b1;
    dbg_ack         = 1'b0;
    case (state)
      ARB_CPU: begin
        dbg_grant = grant_c;
        cpu_stall = grant_c;
      end
      ARB_ACCESS: begin
        mem_enable      = 1'b1;
        mem_mode        = dbg_write ? MEM_MODE_WRITE : MEM_MODE_READ;
        mem_async_write = 1'b0;
        mem_addr        = dbg_addr;
        mem_wdata       = dbg_wdata;
      end
      ARB_STROBE: begin
        mem_enable      = 1'b1;
        mem_mode        = MEM_MODE_WRITE;
        mem_async_write = 1'b1;
        mem_addr        = lat_addr;
        mem_wdata       = lat_wdata;
      end
      ARB_ACK, ARB_HOLD: begin
        mem_enable      = 1'b0;
        mem_mode        = lat_write ? MEM_MODE_WRITE : MEM_MODE_READ;
        mem_async_write = 1'b0;
        mem_addr        = lat_addr;
        mem_wdata       = lat_wdata;
        dbg_ack         = (state == ARB_ACK);
      end
      default: begin
        dbg_grant = 1'b0;
        cpu_stall = 1'b0;
      end
    endcase
  end

endmodule
